// File: rtl/fifo_pkg.sv
// Shared definitions for the circular FIFO and its read-side consumers.
package fifo_pkg;

   // Entry width shared by the FIFO and the nibble packer.
   localparam int FIFO_DW = 4;

   // Packer FSM states.
   typedef enum logic [1:0] {
      FILL  = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } pack_state_t;

   // Number of bits needed to index 'value' distinct items (ceil(log2(value))).
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_nibble_packer.sv
// Read-side consumer of the circular FIFO: drains DW-bit entries and packs
// NIBBLES of them into one word (entry 0 in the LSBs). A flush emits the
// partial word with its entry count and out_last set.
//
// Output handshake: a word is transferred on a rising rd_clk edge where
// out_valid && out_ready. While out_valid is high, out_data, out_count and
// out_last are held stable and out_valid stays high until that transfer.
//
// FIFO side: fifo_read is sampled together with fifo_empty; when both say a
// read happened at edge k, fifo_data is captured at edge k+1.
module fifo_nibble_packer
   import fifo_pkg::*;
#(
   parameter int DW      = FIFO_DW,
   parameter int NIBBLES = 4
) (
   input  logic                        rd_clk,
   input  logic                        reset,
   input  logic                        fifo_empty,
   input  logic [DW-1:0]               fifo_data,
   output logic                        fifo_read,
   input  logic                        flush,
   input  logic                        out_ready,
   output logic                        out_valid,
   output logic [DW*NIBBLES-1:0]       out_data,
   output logic [clog2(NIBBLES+1)-1:0] out_count,
   output logic                        out_last,
   output pack_state_t                 dbg_state
);

   localparam int              OW       = DW * NIBBLES;
   localparam int              CW       = clog2(NIBBLES + 1);
   localparam logic [CW-1:0]   FULL_CNT = CW'(NIBBLES);

   pack_state_t   state_q,      state_d;
   logic [CW-1:0] filled_q,     filled_d;
   logic          inflight_q,   inflight_d;
   logic          flush_pend_q, flush_pend_d;
   logic          out_valid_q,  out_valid_d;
   logic [OW-1:0] out_data_q,   out_data_d;
   logic [CW-1:0] out_count_q,  out_count_d;
   logic          out_last_q,   out_last_d;

   logic          rd_en;
   logic [CW-1:0] fill_cnt;

   // Read strobe: only in FILL, only while the word (including the entry in
   // flight) still has room, and never while reset is asserted.
   always_comb begin
      rd_en = 1'b0;
      if (reset && (state_q == FILL) && !fifo_empty && !flush_pend_q &&
          ((int'(filled_q) + int'(inflight_q)) < NIBBLES)) begin
         rd_en = 1'b1;
      end
   end

   // Next-state logic: capture returning data, then decide FILL/DRAIN/HOLD.
   always_comb begin
      state_d      = state_q;
      filled_d     = filled_q;
      inflight_d   = rd_en;
      flush_pend_d = flush_pend_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_count_d  = out_count_q;
      out_last_d   = out_last_q;
      fill_cnt     = filled_q;

      // An entry requested on the previous edge lands in slot 'filled'.
      if (inflight_q && (filled_q < FULL_CNT)) begin
         out_data_d[int'(filled_q)*DW +: DW] = fifo_data;
         fill_cnt = filled_q + CW'(1);
      end
      filled_d = fill_cnt;

      case (state_q)
         FILL: begin
            if (fill_cnt == FULL_CNT) begin
               // Full word wins; a coincident flush is absorbed.
               state_d     = HOLD;
               out_valid_d = 1'b1;
               out_count_d = FULL_CNT;
               out_last_d  = 1'b0;
            end else if (flush) begin
               if (rd_en) begin
                  // Wait one edge for the entry just requested.
                  state_d      = DRAIN;
                  flush_pend_d = 1'b1;
               end else if (fill_cnt != '0) begin
                  state_d      = HOLD;
                  flush_pend_d = 1'b1;
                  out_valid_d  = 1'b1;
                  out_count_d  = fill_cnt;
                  out_last_d   = 1'b1;
               end else begin
                  // Nothing buffered: the flush has no word to emit.
                  flush_pend_d = 1'b0;
               end
            end
         end
         DRAIN: begin
            if (fill_cnt != '0) begin
               state_d     = HOLD;
               out_valid_d = 1'b1;
               out_count_d = fill_cnt;
               out_last_d  = 1'b1;
            end else begin
               state_d      = FILL;
               flush_pend_d = 1'b0;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d      = FILL;
               filled_d     = '0;
               flush_pend_d = 1'b0;
               out_valid_d  = 1'b0;
               out_data_d   = '0;
               out_count_d  = '0;
               out_last_d   = 1'b0;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   // State and output registers; async reset discards any partial word.
   always_ff @(posedge rd_clk or negedge reset) begin
      if (!reset) begin
         state_q      <= FILL;
         filled_q     <= '0;
         inflight_q   <= 1'b0;
         flush_pend_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_count_q  <= '0;
         out_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         filled_q     <= filled_d;
         inflight_q   <= inflight_d;
         flush_pend_q <= flush_pend_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_count_q  <= out_count_d;
         out_last_q   <= out_last_d;
      end
   end

   assign fifo_read = rd_en;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_count = out_count_q;
   assign out_last  = out_last_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Bench for fifo_nibble_packer: a behavioural FIFO read port, a table of
// directed write/flush vectors, and hand sequences for backpressure,
// flush-with-read-in-flight, absorbed flush, latency and mid-word reset.
module tb_fifo_nibble_packer;
   import fifo_pkg::*;

   localparam int DW = 4;
   localparam int NB = 4;
   localparam int OW = DW * NB;
   localparam int CW = 3;
   localparam int W  = OW + CW + 1;

   logic          rd_clk = 1'b0;
   logic          reset;
   logic          fifo_empty;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_read;
   logic          flush;
   logic          out_ready;
   logic          out_valid;
   logic [OW-1:0] out_data;
   logic [CW-1:0] out_count;
   logic          out_last;
   pack_state_t   dbg_state;

   fifo_nibble_packer #(.DW(DW), .NIBBLES(NB)) dut (
      .rd_clk     (rd_clk),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_read  (fifo_read),
      .flush      (flush),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_count  (out_count),
      .out_last   (out_last),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 rd_clk = ~rd_clk;

   // ---------------- FIFO read-port model ----------------
   logic [DW-1:0] mem [0:255];
   int            wr_ptr = 0;
   int            rd_ptr = 0;

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge rd_clk) begin
      if (fifo_read && !fifo_empty) begin
         fifo_data <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int           n_vec      = 0;
   int           n_err      = 0;
   int           rd_pulses  = 0;
   int           hold_reads = 0;

   typedef struct {
      logic [15:0] wr;
      int          n;
      bit          fl;
      logic [15:0] ed;
      logic [2:0]  ec;
      bit          el;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic wr(input logic [DW-1:0] v);
      mem[wr_ptr] = v;
      wr_ptr      = wr_ptr + 1;
   endtask

   // One clock: sample at the falling edge, return just after the rising edge.
   task automatic step();
      logic [W-1:0] e;
      @(negedge rd_clk);
      if (fifo_read) rd_pulses++;
      if (fifo_read && out_valid) hold_reads++;
      if (reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got last=%0b count=%0d data=%h, required no word",
                     out_last, out_count, out_data);
         end else begin
            e = exp_q.pop_front();
            check("word", 32'({out_last, out_count, out_data}), 32'(e));
         end
      end
      @(posedge rd_clk);
      #1;
   endtask

   task automatic wait_drain(input int limit);
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < limit) begin
         step();
         c++;
      end
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_reads(input int base, input int n);
      int c;
      c = 0;
      while ((rd_ptr - base) < n && c < 40) begin
         step();
         c++;
      end
      check("read_timeout", 32'(rd_ptr - base), 32'(n));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int base;
      int cyc;

      tbl[0] = '{16'h4321, 4, 1'b0, 16'h4321, 3'd4, 1'b0};
      tbl[1] = '{16'h0065, 2, 1'b1, 16'h0065, 3'd2, 1'b1};
      tbl[2] = '{16'h0000, 0, 1'b1, 16'h0000, 3'd0, 1'b0};
      tbl[3] = '{16'h0BA9, 3, 1'b1, 16'h0BA9, 3'd3, 1'b1};
      tbl[4] = '{16'h0007, 1, 1'b1, 16'h0007, 3'd1, 1'b1};
      tbl[5] = '{16'hCDEF, 4, 1'b0, 16'hCDEF, 3'd4, 1'b0};

      reset     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data",  32'(out_data),  32'd0);
      check("rst_count", 32'(out_count), 32'd0);
      check("rst_last",  32'(out_last),  32'd0);
      check("rst_state", 32'(dbg_state), 32'(FILL));
      repeat (3) step();
      reset = 1'b1;
      step();

      // Table-driven vectors.
      for (int i = 0; i < 6; i++) begin
         base = rd_pulses;
         if (tbl[i].n > 0) exp_q.push_back({tbl[i].el, tbl[i].ec, tbl[i].ed});
         for (int j = 0; j < tbl[i].n; j++) wr(tbl[i].wr[j*DW +: DW]);
         repeat (6) step();
         if (tbl[i].fl) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
         end
         wait_drain(40);
         repeat (3) step();
         check("vec_reads", 32'(rd_pulses - base), 32'(tbl[i].n));
         check("vec_state", 32'(dbg_state), 32'(FILL));
         check("vec_valid", 32'(out_valid), 32'd0);
      end

      // Latency: reads start after the write edge, word valid 5 edges later.
      exp_q.push_back({1'b0, 3'd4, 16'h8642});
      wr(4'h2); wr(4'h4); wr(4'h6); wr(4'h8);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         step();
         cyc++;
      end
      check("latency", 32'(cyc), 32'd5);
      wait_drain(20);

      // Backpressure: two words, downstream stalled for 10 cycles.
      out_ready  = 1'b0;
      base       = rd_pulses;
      hold_reads = 0;
      exp_q.push_back({1'b0, 3'd4, 16'h4321});
      exp_q.push_back({1'b0, 3'd4, 16'h8765});
      for (int j = 1; j <= 8; j++) wr(DW'(j));
      repeat (10) step();
      check("bp_reads_stalled", 32'(rd_pulses - base), 32'd4);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data",  32'(out_data),  32'h4321);
      check("bp_state", 32'(dbg_state), 32'(HOLD));
      out_ready = 1'b1;
      wait_drain(40);
      repeat (2) step();
      check("bp_hold_reads", 32'(hold_reads), 32'd0);
      check("bp_reads_total", 32'(rd_pulses - base), 32'd8);

      // Flush on the cycle the third read issues.
      base = rd_ptr;
      exp_q.push_back({1'b1, 3'd3, 16'h0CBA});
      wr(4'hA); wr(4'hB); wr(4'hC);
      wait_reads(base, 2);
      check("inflight_read_now", 32'(fifo_read), 32'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("inflight_drain_valid", 32'(out_valid), 32'd0);
      check("inflight_drain_state", 32'(dbg_state), 32'(DRAIN));
      step();
      check("inflight_hold_valid", 32'(out_valid), 32'd1);
      wait_drain(20);

      // Flush coinciding with the edge that completes a full word.
      base = rd_ptr;
      exp_q.push_back({1'b0, 3'd4, 16'hDCBA});
      wr(4'hA); wr(4'hB); wr(4'hC); wr(4'hD);
      wait_reads(base, 4);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("absorb_valid", 32'(out_valid), 32'd1);
      check("absorb_last",  32'(out_last),  32'd0);
      wait_drain(20);
      repeat (6) step();
      check("absorb_state", 32'(dbg_state), 32'(FILL));

      // Reset mid-word: partial entries discarded, next word is clean.
      base = rd_ptr;
      wr(4'h1); wr(4'h2);
      wait_reads(base, 2);
      repeat (2) step();
      reset = 1'b0;
      #1;
      check("mid_rst_data",  32'(out_data),  32'd0);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_count", 32'(out_count), 32'd0);
      check("mid_rst_state", 32'(dbg_state), 32'(FILL));
      wr(4'h6); wr(4'h7); wr(4'h8); wr(4'h9);
      base = rd_pulses;
      #1;
      check("mid_rst_read_gate", 32'(fifo_read), 32'd0);
      repeat (3) step();
      check("mid_rst_no_reads", 32'(rd_pulses - base), 32'd0);
      reset = 1'b1;
      exp_q.push_back({1'b0, 3'd4, 16'h9876});
      wait_drain(30);
      repeat (3) step();
      check("mid_rst_reads", 32'(rd_pulses - base), 32'd4);
      check("fifo_drained", 32'(fifo_empty), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
